// File: rtl/bintobcd_param_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
interface bintobcd_param_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 8
);
  logic                  i_start;
  logic [WIDTH-1:0]      i_bin;
  logic                  i_signed;
  logic                  o_ready;
  logic                  o_done;
  logic [4*DIGITS-1:0]   o_bcd;
  logic                  o_neg;
  logic                  o_ovf;
  logic [DIGITS-1:0]     o_lz_mask;

  modport master (
    output i_start, i_bin, i_signed,
    input  o_ready, o_done, o_bcd, o_neg, o_ovf, o_lz_mask
  );

  modport slave (
    input  i_start, i_bin, i_signed,
    output o_ready, o_done, o_bcd, o_neg, o_ovf, o_lz_mask
  );
endinterface

// File: rtl/bintobcd_param.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with signed mode, sticky overflow saturation and a leading-zero mask.
module bintobcd_param #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  bintobcd_param_if.slave bus
);
  localparam int unsigned       BCD_W    = 4 * DIGITS;
  localparam int unsigned       CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [BCD_W-1:0]  NINES    = {DIGITS{4'h9}};
  localparam logic [DIGITS-1:0] LZ_RST   = ~DIGITS'(1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]   sr_q, sr_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_o_q, ovf_o_d;
  logic               neg_o_q, neg_o_d;
  logic [DIGITS-1:0]  lz_q, lz_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   step_bcd;
  logic               shift_out;
  logic               fin_ovf;
  logic               zero_run;
  logic [DIGITS-1:0]  lz_fin;

  // One add-3/shift iteration plus the result flags it would produce if final.
  always_comb begin
    adj = sr_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (sr_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = sr_q[4*k +: 4] + 4'd3;
    end
    {shift_out, step_bcd} = {adj, mag_q[WIDTH-1]};
    fin_ovf  = ovf_q | shift_out;
    zero_run = 1'b1;
    lz_fin   = '0;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      zero_run  = zero_run & (step_bcd[4*k +: 4] == 4'd0);
      lz_fin[k] = zero_run & ~fin_ovf;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    sr_d    = sr_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;
    ovf_o_d = ovf_o_q;
    neg_o_d = neg_o_q;
    lz_d    = lz_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          state_d = S_CONV;
          cnt_d   = '0;
          sr_d    = '0;
          ovf_d   = 1'b0;
          neg_d   = bus.i_signed & bus.i_bin[WIDTH-1];
          // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
          mag_d   = neg_d ? (~bus.i_bin + WIDTH'(1)) : bus.i_bin;
        end
      end
      S_CONV: begin
        sr_d  = step_bcd;
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        ovf_d = fin_ovf;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          bcd_d   = fin_ovf ? NINES : step_bcd;
          ovf_o_d = fin_ovf;
          neg_o_d = neg_q;
          lz_d    = lz_fin;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      sr_q    <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
      ovf_o_q <= 1'b0;
      neg_o_q <= 1'b0;
      lz_q    <= LZ_RST;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      sr_q    <= sr_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      bcd_q   <= bcd_d;
      ovf_o_q <= ovf_o_d;
      neg_o_q <= neg_o_d;
      lz_q    <= lz_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.o_ready   = ready_q;
  assign bus.o_done    = done_q;
  assign bus.o_bcd     = bcd_q;
  assign bus.o_neg     = neg_o_q;
  assign bus.o_ovf     = ovf_o_q;
  assign bus.o_lz_mask = lz_q;
endmodule
